decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second PIGRO pipeline stage. It consumes the fetched instruction and PC and feeds the execute stage.
- Contains the 16x32 register file, written by writeback.
- Extracts fields, detects RAW hazards with an in-flight destination scoreboard, and stalls fetch.
- Resolves JMP and squashes the wrong-path instructions that follow a taken jump.
- Opcode encodings come from the shared opcodes header. Data width is `DATA_WIDTH (32).

Parameters:
- HAZ_DEPTH, 2: number of in-flight stages (EX, MEM) tracked for pending register writes.
- SQUASH_N, 2: number of instructions killed after a taken JMP.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- instr_i  in  32  instruction from fetch; held stable by fetch while hazard=1
- pc_i  in  5  PC of instr_i
- wb_en  in  1  writeback register-file write enable
- wb_addr  in  4  writeback destination register
- wb_data  in  32  writeback data
- hazard  out  1  combinational; RAW stall request to fetch
- jump_flag  out  1  registered; taken jump
- jump_dest  out  5  registered; jump target
- valid_o  out  1  decoded instruction valid (0 = bubble)
- op_o  out  5  opcode
- imm_o  out  1  immediate flag, instr[26]
- rd_o  out  4  destination field, instr[25:22]
- a_o  out  32  source A value
- b_o  out  32  source B value, or immediate
- bdest_o  out  5  branch target, instr[13:9]
- pc_o  out  5  PC of the decoded instruction

Behaviour:
- Reset is synchronous and active-high, on the clk rising edge.
  - Every output goes to 0, including hazard.
  - All 16 registers and all scoreboard slots are cleared.
  - The squash counter is cleared.
- Field extraction:
  - opcode = instr[31:27], imm = [26], rd = [25:22], rs1 = [21:18], rs2 = [17:14].
  - imm18 = [17:0], zero-extended to 32 bits. Jump/branch dest = [13:9].
- Sources and writes per opcode:
  - ADD, SUB, MUL: read rs1, and rs2 when imm=0. Write rd. b_o = imm18 when imm=1.
  - NOT: read rs1, write rd.
  - LDW: no register source. Write rd. b_o = imm18 when imm=1, else b_o = {28'b0, rs1 field} (direct address).
  - STR: read rd (data, into a_o) and rs1 (address, into b_o). No write.
  - BRQ: read rs1 into a_o and rs2 into b_o. No write.
  - JMP, NOP: no sources, no write. Unknown opcodes are treated as NOP.
- Register file:
  - Two combinational read ports.
  - Write occurs on posedge when wb_en=1.
  - If wb_en=1 and wb_addr equals a source in the same cycle, the read returns wb_data (write-through bypass).
- Scoreboard:
  - HAZ_DEPTH slots of {v, rd}. Every cycle, slot[k] shifts to slot[k+1] and the last slot drops.
  - slot0 is loaded with {1, rd} when a writing instruction issues; otherwise {0, x}.
- Hazard:
  - hazard = 1 when instr_i is not squashed and any used source equals slot[k].rd with slot[k].v=1.
  - While hazard=1: a bubble is issued (valid_o=0, op_o=NOP, slot0 invalid) and jump_flag=0.
  - The register file still accepts writeback while stalled.
- Pipeline timing:
  - Outputs are registered, giving 1-cycle latency from instr_i to the execute-facing outputs.
  - A bubble is issued for squashed instructions as well.
- JMP (issued, not squashed, no stall):
  - Next cycle: jump_flag=1 for exactly one cycle.
  - jump_dest = dest when imm=1 (absolute), else pc_i + dest mod 32 (relative, wraps 31+1 -> 0).
  - The squash counter loads SQUASH_N. Each following cycle with the counter nonzero converts instr_i to a bubble and decrements the counter.
  - A squashed instruction never raises hazard and never loads the scoreboard.
  - A JMP arriving while squashing is itself squashed.
- Simultaneous events: reset overrides all other activity.
- Reset mid-stall: the stall ends and the scoreboard empties.

Test Plan:
- Reset and read-after-write:
  - Stimulus: rst for 2 cycles, then wb_en=1, wb_addr=3, wb_data=7, then decode ADD R5,R3,R4 with R4=0.
  - Response: all outputs 0 during reset, then a_o=7, b_o=0, valid_o=1.
- RAW stall:
  - Stimulus: MUL R1,R2,R3 followed by ADD R5,R1,R4 held stable.
  - Response: hazard=1 for 2 cycles with 2 bubbles (valid_o=0), then ADD issues with valid_o=1. Each bubble clears hazard as the slot drains.
- Immediate forms:
  - Stimulus: SUBi R7,R12,#11 with R12=20.
  - Response: a_o=20, b_o=11, imm_o=1, no hazard from the rs2 field.
- Relative jump with wrap:
  - Stimulus: JMP rel, dest=3, at pc=30.
  - Response: jump_flag=1 for one cycle, jump_dest=1. The next 2 instructions give valid_o=0 and hazard=0, even if they conflict with the scoreboard.
- Absolute jump and write-through bypass:
  - Stimulus: JMP abs dest=15 at pc=19. Separately, wb_en=1 to R10 with data 5 in the same cycle as BRQ R10,R11 is decoded.
  - Response: jump_dest=15. For the BRQ, a_o=5 and bdest_o equals the encoded target.
- Reset during stall:
  - Stimulus: assert rst while hazard=1.
  - Response: next cycle hazard=0, scoreboard empty, and the held instruction issues immediately after rst drops.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: register file, field extraction, RAW scoreboard,
// jump resolution and wrong-path squashing.
module decode_stage #(
  parameter int HAZ_DEPTH = 2,
  parameter int SQUASH_N  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic [4:0]  pc_i,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        hazard,
  output logic        jump_flag,
  output logic [4:0]  jump_dest,
  output logic        valid_o,
  output logic [4:0]  op_o,
  output logic        imm_o,
  output logic [3:0]  rd_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  bdest_o,
  output logic [4:0]  pc_o
);

  localparam int DATA_WIDTH = 32;
  localparam int SQW = (SQUASH_N < 1) ? 1 : $clog2(SQUASH_N + 1);

  // Opcode encodings shared with fetch/execute.
  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_NOT = 5'd4;
  localparam logic [4:0] OP_LDW = 5'd5;
  localparam logic [4:0] OP_STR = 5'd6;
  localparam logic [4:0] OP_BRQ = 5'd7;
  localparam logic [4:0] OP_JMP = 5'd8;

  // Instruction fields
  logic [4:0]  opcode;
  logic        imm_bit;
  logic [3:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm18_ext;
  logic [4:0]  dest_f;

  assign opcode    = instr_i[31:27];
  assign imm_bit   = instr_i[26];
  assign rd_f      = instr_i[25:22];
  assign rs1_f     = instr_i[21:18];
  assign rs2_f     = instr_i[17:14];
  assign imm18_ext = {14'b0, instr_i[17:0]};
  assign dest_f    = instr_i[13:9];

  // State
  logic [DATA_WIDTH-1:0] regs_q [16];
  logic                  slot_v_q  [HAZ_DEPTH];
  logic [3:0]            slot_rd_q [HAZ_DEPTH];
  logic [SQW-1:0]        squash_q;

  logic        jump_flag_q, valid_q, imm_q;
  logic [4:0]  jump_dest_q, op_q, bdest_q, pc_q;
  logic [3:0]  rd_q;
  logic [31:0] a_q, b_q;

  // Decode control
  logic       use_a, use_b, writes, b_imm_sel, b_dir, known;
  logic [3:0] addr_a, addr_b;

  // Per-opcode source usage, write intent and B-operand selection
  always_comb begin
    use_a     = 1'b0;
    use_b     = 1'b0;
    addr_a    = rs1_f;
    addr_b    = rs2_f;
    writes    = 1'b0;
    b_imm_sel = 1'b0;
    b_dir     = 1'b0;
    known     = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL: begin
        use_a     = 1'b1;
        use_b     = !imm_bit;
        writes    = 1'b1;
        b_imm_sel = imm_bit;
      end
      OP_NOT: begin
        use_a  = 1'b1;
        writes = 1'b1;
      end
      OP_LDW: begin
        writes    = 1'b1;
        b_imm_sel = imm_bit;
        b_dir     = !imm_bit;
      end
      OP_STR: begin
        use_a  = 1'b1;
        addr_a = rd_f;
        use_b  = 1'b1;
        addr_b = rs1_f;
      end
      OP_BRQ: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      OP_JMP, OP_NOP: ;
      default: known = 1'b0;
    endcase
  end

  // Read ports with write-through bypass from writeback
  logic [31:0] rd_a_val, rd_b_val;
  assign rd_a_val = (wb_en && wb_addr == addr_a) ? wb_data : regs_q[addr_a];
  assign rd_b_val = (wb_en && wb_addr == addr_b) ? wb_data : regs_q[addr_b];

  // Scoreboard match per slot
  logic [HAZ_DEPTH-1:0] slot_hit;
  generate
    for (genvar gi = 0; gi < HAZ_DEPTH; gi++) begin : g_hit
      assign slot_hit[gi] = slot_v_q[gi] &&
                            ((use_a && slot_rd_q[gi] == addr_a) ||
                             (use_b && slot_rd_q[gi] == addr_b));
    end
  endgenerate

  logic squashed, stall, issue, take_jmp;
  assign squashed = (squash_q != '0);
  assign stall    = !squashed && (|slot_hit);
  assign issue    = !squashed && !stall;
  assign take_jmp = issue && (opcode == OP_JMP);

  // Reset forces the stall request low immediately
  assign hazard = stall && !rst;

  // Next-state values for execute-facing outputs
  logic [31:0] a_d, b_d;
  logic [4:0]  jump_dest_d;
  always_comb begin
    a_d = use_a ? rd_a_val : 32'd0;
    if (b_imm_sel)  b_d = imm18_ext;
    else if (b_dir) b_d = {28'b0, rs1_f};
    else if (use_b) b_d = rd_b_val;
    else            b_d = 32'd0;
    jump_dest_d = imm_bit ? dest_f : (pc_i + dest_f);
  end

  // Register file write from writeback (also while stalled)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Scoreboard shift: slot0 takes issuing writers, last slot drops
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < HAZ_DEPTH; k++) begin
        slot_v_q[k]  <= 1'b0;
        slot_rd_q[k] <= '0;
      end
    end else begin
      slot_v_q[0]  <= issue && writes;
      slot_rd_q[0] <= rd_f;
      for (int k = 1; k < HAZ_DEPTH; k++) begin
        slot_v_q[k]  <= slot_v_q[k-1];
        slot_rd_q[k] <= slot_rd_q[k-1];
      end
    end
  end

  // Squash counter: load on taken jump, count down through wrong path
  always_ff @(posedge clk) begin
    if (rst)           squash_q <= '0;
    else if (take_jmp) squash_q <= SQW'(SQUASH_N);
    else if (squashed) squash_q <= squash_q - 1'b1;
  end

  // Execute-facing pipeline register; bubbles carry all-zero fields
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op_q        <= OP_NOP;
      imm_q       <= 1'b0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bdest_q     <= '0;
      pc_q        <= '0;
      jump_flag_q <= 1'b0;
      jump_dest_q <= '0;
    end else begin
      jump_flag_q <= take_jmp;
      if (take_jmp) jump_dest_q <= jump_dest_d;
      if (issue) begin
        valid_q <= 1'b1;
        op_q    <= known ? opcode : OP_NOP;
        imm_q   <= imm_bit;
        rd_q    <= rd_f;
        a_q     <= a_d;
        b_q     <= b_d;
        bdest_q <= dest_f;
        pc_q    <= pc_i;
      end else begin
        valid_q <= 1'b0;
        op_q    <= OP_NOP;
        imm_q   <= 1'b0;
        rd_q    <= '0;
        a_q     <= '0;
        b_q     <= '0;
        bdest_q <= '0;
        pc_q    <= '0;
      end
    end
  end

  assign jump_flag = jump_flag_q;
  assign jump_dest = jump_dest_q;
  assign valid_o   = valid_q;
  assign op_o      = op_q;
  assign imm_o     = imm_q;
  assign rd_o      = rd_q;
  assign a_o       = a_q;
  assign b_o       = b_q;
  assign bdest_o   = bdest_q;
  assign pc_o      = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_NOT = 5'd4;
  localparam logic [4:0] OP_LDW = 5'd5;
  localparam logic [4:0] OP_BRQ = 5'd7;
  localparam logic [4:0] OP_JMP = 5'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic [4:0]  pc_i;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        hazard, jump_flag, valid_o, imm_o;
  logic [4:0]  jump_dest, op_o, bdest_o, pc_o;
  logic [3:0]  rd_o;
  logic [31:0] a_o, b_o;

  int n_checks = 0;
  int n_pass   = 0;

  decode_stage #(.HAZ_DEPTH(2), .SQUASH_N(2)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .pc_i(pc_i),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .hazard(hazard), .jump_flag(jump_flag), .jump_dest(jump_dest),
    .valid_o(valid_o), .op_o(op_o), .imm_o(imm_o), .rd_o(rd_o),
    .a_o(a_o), .b_o(b_o), .bdest_o(bdest_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
      $display("check %-14s got %0d ok", tag, obs);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic imm,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [17:0] low);
    return {op, imm, rd, rs1, low};
  endfunction

  // Advance one clock; registered outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [3:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [4:0] pc);
    instr_i = ins; pc_i = pc;
  endtask

  initial begin
    rst = 1'b1;
    wb(1'b0, 4'd0, 32'd0);
    // Conflicting-looking instruction during reset: hazard must stay 0
    drive(mk(OP_ADD, 1'b0, 4'd1, 4'd1, {4'd1, 14'd0}), 5'd3);

    // Reset for two cycles
    cyc();
    cyc();
    check("rst_valid", valid_o, 0);
    check("rst_op", op_o, 0);
    check("rst_a", a_o, 0);
    check("rst_jflag", jump_flag, 0);
    check("rst_jdest", jump_dest, 0);
    check("rst_hazard", hazard, 0);
    check("rst_pc", pc_o, 0);

    // Write R3=7, then ADD R5,R3,R4
    rst = 1'b0;
    drive(32'd0, 5'd0);
    wb(1'b1, 4'd3, 32'd7);
    cyc();
    wb(1'b0, 4'd0, 32'd0);
    drive(mk(OP_ADD, 1'b0, 4'd5, 4'd3, {4'd4, 14'd0}), 5'd1);
    cyc();
    check("add_valid", valid_o, 1);
    check("add_a", a_o, 7);
    check("add_b", b_o, 0);
    check("add_op", op_o, OP_ADD);
    check("add_rd", rd_o, 5);
    check("add_pc", pc_o, 1);

    // RAW stall: MUL R1,R2,R3 then ADD R5,R1,R4 held
    drive(mk(OP_MUL, 1'b0, 4'd1, 4'd2, {4'd3, 14'd0}), 5'd2);
    cyc();
    check("mul_op", op_o, OP_MUL);
    drive(mk(OP_ADD, 1'b0, 4'd5, 4'd1, {4'd4, 14'd0}), 5'd3);
    #1 check("raw_haz1", hazard, 1);
    cyc();
    check("bub1_valid", valid_o, 0);
    check("bub1_op", op_o, OP_NOP);
    check("raw_haz2", hazard, 1);
    wb(1'b1, 4'd1, 32'd42);      // writeback lands while stalled
    cyc();
    wb(1'b0, 4'd0, 32'd0);
    check("bub2_valid", valid_o, 0);
    #1 check("raw_haz3", hazard, 0);
    cyc();
    check("raw_valid", valid_o, 1);
    check("raw_a", a_o, 42);
    check("raw_pc", pc_o, 3);

    // LDW R0 direct address 9, then SUBi R7,R12,#11 (rs2 field 0 = slot0 rd)
    drive(32'd0, 5'd0);
    wb(1'b1, 4'd12, 32'd20);
    cyc();
    wb(1'b0, 4'd0, 32'd0);
    drive(mk(OP_LDW, 1'b0, 4'd0, 4'd9, 18'd0), 5'd4);
    cyc();
    check("ldw_b", b_o, 9);
    drive(mk(OP_SUB, 1'b1, 4'd7, 4'd12, 18'd11), 5'd5);
    #1 check("subi_haz", hazard, 0);
    cyc();
    check("subi_valid", valid_o, 1);
    check("subi_a", a_o, 20);
    check("subi_b", b_o, 11);
    check("subi_imm", imm_o, 1);

    // Relative JMP dest=3 at pc=30 -> 1; slot1 still holds R7
    drive(mk(OP_JMP, 1'b0, 4'd0, 4'd0, {4'd0, 5'd3, 9'd0}), 5'd30);
    cyc();
    check("jrel_flag", jump_flag, 1);
    check("jrel_dest", jump_dest, 1);
    drive(mk(OP_ADD, 1'b0, 4'd1, 4'd7, {4'd7, 14'd0}), 5'd31);
    #1 check("sq1_haz", hazard, 0);
    cyc();
    check("sq1_valid", valid_o, 0);
    check("jrel_flag1c", jump_flag, 0);
    // A JMP on the wrong path is squashed too
    drive(mk(OP_JMP, 1'b1, 4'd0, 4'd0, {4'd0, 5'd20, 9'd0}), 5'd0);
    #1 check("sq2_haz", hazard, 0);
    cyc();
    check("sq2_valid", valid_o, 0);
    check("sq2_jflag", jump_flag, 0);

    // Absolute JMP dest=15 at pc=19
    drive(mk(OP_JMP, 1'b1, 4'd0, 4'd0, {4'd0, 5'd15, 9'd0}), 5'd19);
    cyc();
    check("jabs_flag", jump_flag, 1);
    check("jabs_dest", jump_dest, 15);
    drive(32'd0, 5'd0);
    wb(1'b1, 4'd11, 32'd9);
    cyc();
    wb(1'b0, 4'd0, 32'd0);
    cyc();

    // BRQ R10,R11 with R10 written through in the same cycle
    drive(mk(OP_BRQ, 1'b0, 4'd0, 4'd10, {4'd11, 5'd13, 9'd0}), 5'd7);
    wb(1'b1, 4'd10, 32'd5);
    cyc();
    wb(1'b0, 4'd0, 32'd0);
    check("brq_valid", valid_o, 1);
    check("brq_a", a_o, 5);
    check("brq_b", b_o, 9);
    check("brq_bdest", bdest_o, 13);
    check("brq_op", op_o, OP_BRQ);

    // Unknown opcode decodes as NOP
    drive(mk(5'd31, 1'b0, 4'd0, 4'd0, 18'd0), 5'd8);
    cyc();
    check("unk_op", op_o, OP_NOP);

    // Reset during a stall: NOT R8,R6 then ADD R9,R8,R0
    drive(mk(OP_NOT, 1'b0, 4'd8, 4'd6, 18'd0), 5'd9);
    cyc();
    drive(mk(OP_ADD, 1'b0, 4'd9, 4'd8, 18'd0), 5'd10);
    #1 check("rs_haz_pre", hazard, 1);
    rst = 1'b1;
    #1 check("rs_haz_in", hazard, 0);
    cyc();
    check("rs_valid", valid_o, 0);
    rst = 1'b0;
    #1 check("rs_haz_post", hazard, 0);
    cyc();
    check("rs_issue", valid_o, 1);
    check("rs_op", op_o, OP_ADD);
    check("rs_a", a_o, 0);
    check("rs_pc", pc_o, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
